// File: rtl/gcd_operand_sequencer.sv
// gcd_operand_sequencer: buffers operand pairs in a 2-entry FIFO, drives the
// GCD core's shared operand bus A-then-B with a one-cycle start, waits for the
// core's done rising edge and returns the result over a valid/ready stream.
// Pairs with a zero operand are answered locally without starting the core.
// Optional build macro: GCD_SEQ_TIMEOUT_EN adds a WAIT watchdog (TO_CYCLES).
module gcd_operand_sequencer #(
    parameter int WIDTH     = 16,
    parameter int TO_CYCLES = 1023
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             gcd_start,
    output logic [WIDTH-1:0] gcd_data,
    input  logic             gcd_done,
    input  logic [WIDTH-1:0] gcd_result,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_err,
    output logic             busy
);

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } pair_t;

    typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, WAIT, OUT} state_t;

    state_t     state_q, state_d;
    pair_t      fifo_q [2];
    logic       wr_ptr_q, rd_ptr_q;
    logic [1:0] count_q;
    pair_t      head, op_q;
    logic       push, pop, bypass;
    logic       done_q, done_rise, to_hit;

    assign head      = fifo_q[rd_ptr_q];
    assign in_ready  = (count_q != 2'd2);
    assign push      = in_valid && in_ready;
    // The FIFO only drains when the FSM leaves IDLE, so one pair is in flight.
    assign pop       = (state_q == IDLE) && (count_q != 2'd0);
    assign bypass    = (head.a == '0) || (head.b == '0);
    // Only a fresh done edge counts; a level left over from a prior run is ignored.
    assign done_rise = gcd_done && !done_q;

    // FIFO storage, no reset needed: occupancy is tracked by count_q
    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q] <= {in_a, in_b};
    end

    // FIFO pointers and occupancy; simultaneous push and pop leaves count unchanged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) wr_ptr_q <= !wr_ptr_q;
            if (pop)  rd_ptr_q <= !rd_ptr_q;
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: ;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state. OUT->IDLE->LOAD_A keeps two cycles between a done capture
    // and the next start, which the core needs to drop done and return idle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pop) state_d = bypass ? OUT : LOAD_A;
            LOAD_A:  state_d = LOAD_B;
            LOAD_B:  state_d = WAIT;
            WAIT:    if (done_rise || to_hit) state_d = OUT;
            OUT:     if (res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign gcd_start = (state_q == LOAD_A);
    assign res_valid = (state_q == OUT);
    assign busy      = (state_q != IDLE) || (count_q != 2'd0);

    // Operand bus mux, decoded from state over registered operands only
    always_comb begin
        gcd_data = '0;
        if (state_q == LOAD_A)      gcd_data = op_q.a;
        else if (state_q == LOAD_B) gcd_data = op_q.b;
    end

    // Operand latch, done edge tracker and result register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q   <= 1'b0;
            op_q     <= '0;
            res_data <= '0;
        end else begin
            done_q <= gcd_done;
            if (pop) begin
                op_q <= head;
                // gcd(0,x) = x and gcd(0,0) = 0 both fall out of A|B
                if (bypass) res_data <= head.a | head.b;
            end
            if (state_q == WAIT) begin
                if (done_rise)   res_data <= gcd_result;
                else if (to_hit) res_data <= '0;
            end
        end
    end

`ifdef GCD_SEQ_TIMEOUT_EN
    localparam int TW = (TO_CYCLES > 1) ? $clog2(TO_CYCLES) : 1;

    logic [TW-1:0] wd_q;

    // wd_q holds the number of WAIT cycles already spent; the limit fires on
    // the TO_CYCLES-th WAIT cycle, and a done edge in that cycle takes priority.
    assign to_hit = (state_q == WAIT) && !done_rise && (wd_q == TW'(TO_CYCLES - 1));

    // Watchdog counter and abort flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q    <= '0;
            res_err <= 1'b0;
        end else begin
            if (state_q == LOAD_B)    wd_q <= '0;
            else if (state_q == WAIT) wd_q <= wd_q + TW'(1);
            if (pop && bypass)                      res_err <= 1'b0;
            else if ((state_q == WAIT) && done_rise) res_err <= 1'b0;
            else if (to_hit)                        res_err <= 1'b1;
        end
    end
`else
    logic unused_to;

    assign to_hit    = 1'b0;
    assign res_err   = 1'b0;
    assign unused_to = (TO_CYCLES == 0);
`endif

endmodule

// File: tb/tb_gcd_operand_sequencer.sv
// tb_gcd_operand_sequencer: directed plus random stimulus against a
// behavioural GCD core and a queue-based scoreboard of expected results.
module tb_gcd_operand_sequencer;

    localparam int W  = 16;
    localparam int TO = 20;

    logic         clk = 1'b0, rst_n = 1'b0;
    logic         in_valid = 1'b0, res_ready = 1'b0, gcd_done = 1'b0;
    logic [W-1:0] in_a = '0, in_b = '0, gcd_result = '0;
    logic         in_ready, gcd_start, res_valid, res_err, busy;
    logic [W-1:0] gcd_data, res_data;

    gcd_operand_sequencer #(.WIDTH(W), .TO_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .gcd_start(gcd_start), .gcd_data(gcd_data),
        .gcd_done(gcd_done), .gcd_result(gcd_result), .res_valid(res_valid),
        .res_ready(res_ready), .res_data(res_data), .res_err(res_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int n_chk = 0, n_pass = 0;
    int n_res = 0, n_core = 0, n_start = 0;
    int out_rise_cyc = 0, done_cyc = 0;
    bit have_out = 0, rnd = 0, core_mute = 0, hs = 0, pv = 0;
    logic [W-1:0] pd;
    logic [W:0]   e;
    logic [W:0]     exp_q  [$];   // {err, data} in delivery order
    logic [2*W-1:0] core_q [$];   // {a, b} the core should be handed
    int lat_min = 3, lat_max = 3, hold_min = 1, hold_max = 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic logic [W-1:0] gcd_ref(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] t;
        if (a == '0 || b == '0) return a | b;
        while (b != '0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // Commit the handshakes that the next rising edge will perform, then
    // advance to the following falling edge and observe.
    task automatic step();
        hs = 0;
        if (res_valid && res_ready) begin
            hs = 1;
            n_res++;
            chk("res_expected", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("res_data", 32'(res_data), 32'(e[W-1:0]));
                chk("res_err", 32'(res_err), 32'(e[W]));
            end
        end
        if (in_valid && in_ready) begin
            exp_q.push_back({1'b0, gcd_ref(in_a, in_b)});
            if (in_a != '0 && in_b != '0) begin
                core_q.push_back({in_a, in_b});
                n_core++;
            end
        end
        pv = res_valid;
        pd = res_data;
        @(negedge clk);
        if (res_valid && pv && !hs) chk("res_hold", 32'(res_data), 32'(pd));
        if (res_valid && !pv) begin
            out_rise_cyc = cyc;
            have_out     = 1;
        end
        if (rnd) res_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic push(input logic [W-1:0] a, input logic [W-1:0] b, output int acc);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        for (int i = 0; i < 500 && !in_ready; i++) step();
        chk("push_ready", 32'(in_ready), 1);
        step();
        acc      = cyc;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input int max);
        for (int i = 0; i < max && !res_valid; i++) step();
        chk("valid_seen", 32'(res_valid), 1);
    endtask

    task automatic wait_idle(input int max);
        for (int i = 0; i < max && (busy || exp_q.size() != 0); i++) step();
        chk("idle_reached", 32'(!busy && exp_q.size() == 0), 1);
    endtask

    // Behavioural core: latches A with start, B the cycle after, then raises
    // done with the GCD after a latency and holds it for a chosen count.
    int           c_phase = 0, c_lat = 0, c_hold = 0;
    logic [W-1:0] c_a, c_b;
    logic [2*W-1:0] ce;
    always @(negedge clk) begin
        if (!rst_n) begin
            c_phase    = 0;
            gcd_done   = 1'b0;
            gcd_result = W'($urandom);
        end else if (gcd_start) begin
            n_start++;
            if (have_out) chk("start_gap", 32'((cyc - out_rise_cyc) >= 2), 1);
            c_a      = gcd_data;
            c_phase  = 1;
            gcd_done = 1'b0;
        end else begin
            case (c_phase)
                1: begin
                    c_b = gcd_data;
                    chk("core_expected", 32'(core_q.size() > 0), 1);
                    if (core_q.size() > 0) begin
                        ce = core_q.pop_front();
                        chk("core_a", 32'(c_a), 32'(ce[2*W-1:W]));
                        chk("core_b", 32'(c_b), 32'(ce[W-1:0]));
                    end
                    c_lat   = $urandom_range(lat_min, lat_max);
                    c_phase = 2;
                end
                2: if (!core_mute) begin
                    if (c_lat == 0) begin
                        gcd_done   = 1'b1;
                        gcd_result = gcd_ref(c_a, c_b);
                        done_cyc   = cyc;
                        c_hold     = $urandom_range(hold_min, hold_max);
                        c_phase    = 3;
                    end else c_lat--;
                end
                3: begin
                    c_hold--;
                    if (c_hold == 0) begin
                        gcd_done   = 1'b0;
                        gcd_result = W'($urandom);
                        c_phase    = 0;
                    end
                end
                default: ;
            endcase
        end
    end

    initial begin
        int acc, t0, base, k;
        logic [W-1:0] a, b;

        // reset values
        step(); step();
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_start", 32'(gcd_start), 0);
        chk("rst_data", 32'(gcd_data), 0);
        chk("rst_valid", 32'(res_valid), 0);
        chk("rst_res", 32'(res_data), 0);
        chk("rst_err", 32'(res_err), 0);
        chk("rst_busy", 32'(busy), 0);
        rst_n = 1'b1;
        step();

        // single core run (48,18)
        res_ready = 1'b1;
        push(48, 18, acc);
        chk("t1_no_start", 32'(gcd_start), 0);
        step();
        chk("t1_start", 32'(gcd_start), 1);
        chk("t1_data_a", 32'(gcd_data), 48);
        step();
        chk("t1_start_1cyc", 32'(gcd_start), 0);
        chk("t1_data_b", 32'(gcd_data), 18);
        step();
        chk("t1_data_wait", 32'(gcd_data), 0);
        wait_valid(50);
        chk("t1_lat", cyc - done_cyc, 1);
        chk("t1_res", 32'(res_data), 6);
        chk("t1_err", 32'(res_err), 0);
        wait_idle(50);
        chk("t1_starts", n_start, 1);

        // zero-operand bypass
        base = n_start;
        push(0, 35, acc);
        chk("byp1_early", 32'(res_valid), 0);
        step();
        chk("byp1_valid", 32'(res_valid), 1);
        chk("byp1_data", 32'(res_data), 35);
        push(0, 0, acc);
        chk("byp2_early", 32'(res_valid), 0);
        step();
        chk("byp2_valid", 32'(res_valid), 1);
        chk("byp2_data", 32'(res_data), 0);
        wait_idle(20);
        chk("byp_nostart", n_start, base);

        // fill the FIFO while the output is stalled
        res_ready = 1'b0;
        lat_min = 2; lat_max = 2;
        push(7, 7, acc); push(7, 7, acc); push(7, 7, acc);
        chk("full_ready", 32'(in_ready), 0);
        repeat (15) step();
        chk("full_ready_held", 32'(in_ready), 0);
        chk("full_valid", 32'(res_valid), 1);
        chk("full_data", 32'(res_data), 7);
        base = n_res;
        res_ready = 1'b1;
        wait_idle(200);
        chk("full_drain", n_res - base, 3);

        // core holds done for two cycles
        hold_min = 2; hold_max = 2; lat_min = 1; lat_max = 4;
        base = n_res;
        push(12, 8, acc); push(21, 14, acc);
        wait_idle(200);
        chk("hold_results", n_res - base, 2);

        // reset in the middle of WAIT
        hold_min = 1; hold_max = 1; lat_min = 40; lat_max = 40;
        push(100, 75, acc);
        repeat (5) step();
        chk("mid_busy", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(in_ready), 1);
        chk("mid_rst_start", 32'(gcd_start), 0);
        chk("mid_rst_data", 32'(gcd_data), 0);
        chk("mid_rst_valid", 32'(res_valid), 0);
        chk("mid_rst_res", 32'(res_data), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        exp_q.delete();
        core_q.delete();
        step(); step();
        rst_n = 1'b1;
        base = n_res;
        repeat (60) step();
        chk("mid_no_result", n_res - base, 0);
        chk("mid_idle", 32'(busy), 0);

        // random pairs, random back-pressure, random core timing
        lat_min = 0; lat_max = 8; hold_min = 1; hold_max = 2;
        rnd = 1;
        base = n_res;
        for (int i = 0; i < 60; i++) begin
            k = $urandom_range(1, 40);
            a = ($urandom_range(0, 5) == 0) ? '0 : W'(k * $urandom_range(1, 50));
            b = ($urandom_range(0, 5) == 0) ? '0 : W'(k * $urandom_range(1, 50));
            push(a, b, acc);
            repeat ($urandom_range(0, 3)) step();
        end
        rnd = 0;
        res_ready = 1'b1;
        wait_idle(3000);
        chk("rand_results", n_res - base, 60);

`ifdef GCD_SEQ_TIMEOUT_EN
        // watchdog abort when the core never finishes
        core_mute = 1;
        res_ready = 1'b0;
        push(9, 6, acc);
        for (int i = 0; i < 10 && !gcd_start; i++) step();
        chk("to_start", 32'(gcd_start), 1);
        t0 = cyc;
        for (int i = 0; i < 100 && !res_valid; i++) step();
        chk("to_lat", cyc - t0, 2 + TO);
        chk("to_data", 32'(res_data), 0);
        chk("to_err", 32'(res_err), 1);
        void'(exp_q.pop_back());
        exp_q.push_back({1'b1, W'(0)});
        res_ready = 1'b1;
        wait_idle(20);
`endif

        chk("start_count", n_start, n_core);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
